// File: rtl/instr_fetch_unit_pkg.sv
// Defaults shared by the fetch unit, the instruction memory and decode.
package instr_fetch_unit_pkg;

  localparam int unsigned IFU_ADDR_W    = 16;
  localparam int unsigned IFU_INSTR_W   = 16;
  localparam int unsigned IFU_PC_STEP   = 2;
  localparam int unsigned IFU_RESET_PC  = 0;
  localparam int unsigned IFU_BUF_DEPTH = 2;

  // Width of an occupancy counter that must hold the values 0..depth.
  function automatic int unsigned ifu_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, instr} entries between the
// memory return and decode. Flush empties it in one edge and beats push/pop.
module fetch_buffer
  import instr_fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = IFU_BUF_DEPTH,
  parameter  int unsigned W     = IFU_ADDR_W + IFU_INSTR_W,
  localparam int unsigned CNT_W = ifu_cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]       mem_q [DEPTH];
  logic [W-1:0]       mem_d [DEPTH];
  logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    if (p == IDX_W'(DEPTH - 1)) return '0;
    return p + IDX_W'(1);
  endfunction

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state: pointers and count, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: owns the PC, issues one memory read at a time,
// presents returned words to decode (bypassing the buffer when it is empty),
// and discards stale words on redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W    = IFU_ADDR_W,
  parameter int unsigned INSTR_W   = IFU_INSTR_W,
  parameter int unsigned RESET_PC  = IFU_RESET_PC,
  parameter int unsigned PC_STEP   = IFU_PC_STEP,
  parameter int unsigned BUF_DEPTH = IFU_BUF_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  pointer,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               misalign_err
);

  localparam int unsigned ENT_W = ADDR_W + INSTR_W;
  localparam int unsigned CNT_W = ifu_cnt_w(BUF_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              misalign_q, misalign_d;

  logic [ENT_W-1:0]  buf_head;
  logic              buf_valid;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_push, buf_pop;
  logic [ENT_W-1:0]  head_ent;
  logic              pop, issue;
  logic [CNT_W:0]    occ_now, slot_lim;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .W     (ENT_W)
  ) u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (buf_push),
    .push_data  ({req_pc_q, instr_in}),
    .pop        (buf_pop),
    .head_data  (buf_head),
    .head_valid (buf_valid),
    .count      (buf_count)
  );

  // Handshake, buffer control and issue decision.
  always_comb begin
    head_ent = '0;
    if (buf_valid)       head_ent = buf_head;
    else if (inflight_q) head_ent = {req_pc_q, instr_in};
    pop      = (buf_valid | inflight_q) & instr_ready;
    buf_pop  = buf_valid & instr_ready;
    // The returning word bypasses straight to decode when the buffer is empty
    // and decode takes it; otherwise it joins the tail. Redirect kills it.
    buf_push = inflight_q & ~redirect_valid & (buf_valid | ~instr_ready);
    // Words held after this edge = count + inflight - pop; a new read may go
    // out only if its return is guaranteed a slot. Counting the pop keeps
    // one word per cycle flowing with a single in-flight read.
    occ_now  = {1'b0, buf_count} + (CNT_W+1)'(inflight_q);
    slot_lim = (CNT_W+1)'(BUF_DEPTH) + (CNT_W+1)'(pop);
    issue    = ~redirect_valid & (occ_now < slot_lim);
  end

  // Next PC, in-flight tracking and misalignment flag.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    misalign_d = redirect_valid & redirect_target[0];
    if (redirect_valid) begin
      pc_d = {redirect_target[ADDR_W-1:1], 1'b0};
    end else if (issue) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + ADDR_W'(PC_STEP);
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= ADDR_W'(RESET_PC);
      inflight_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      misalign_q <= misalign_d;
    end
  end

  // Address of the outstanding read; only meaningful while inflight_q is set.
  always_ff @(posedge clk) begin
    req_pc_q <= req_pc_d;
  end

  assign pointer             = pc_q;
  assign instr_valid         = buf_valid | inflight_q;
  assign {pc_out, instr_out} = head_ent;
  assign misalign_err        = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a registered instruction memory.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pointer;
  logic [15:0] instr_in;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        misalign_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .pointer         (pointer),
    .instr_in        (instr_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  // Memory contents: word at byte address a is a ^ 16'h5A5A.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Registered instruction memory: data one cycle after pointer.
  always @(posedge clk) instr_in <= mem_word(pointer);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    tick(); tick();
    total_cnt++; if (pointer !== 16'h0000) $display("FAIL reset_pointer got=%h want=%h", pointer, 16'h0000); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", instr_valid); else pass_cnt++;
    total_cnt++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign got=%b want=0", misalign_err); else pass_cnt++;
    total_cnt++; if (instr_out !== 16'h0000) $display("FAIL reset_instr got=%h want=0000", instr_out); else pass_cnt++;
    total_cnt++; if (pc_out !== 16'h0000) $display("FAIL reset_pc got=%h want=0000", pc_out); else pass_cnt++;
  endtask

  // Cycle c counts from rst release: pointer=2c, word for pc 2(c-1) visible from c=1.
  task automatic test_stream();
    logic [15:0] exp_ptr, exp_pc;
    rst = 1'b0; instr_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      exp_ptr = 16'(2 * c);
      exp_pc  = 16'(2 * (c - 1));
      total_cnt++; if (pointer !== exp_ptr) $display("FAIL stream_pointer c=%0d got=%h want=%h", c, pointer, exp_ptr); else pass_cnt++;
      total_cnt++; if (instr_valid !== (c >= 1)) $display("FAIL stream_valid c=%0d got=%b want=%b", c, instr_valid, (c >= 1)); else pass_cnt++;
      if (c >= 1) begin
        total_cnt++; if (pc_out !== exp_pc) $display("FAIL stream_pc c=%0d got=%h want=%h", c, pc_out, exp_pc); else pass_cnt++;
        total_cnt++; if (instr_out !== mem_word(exp_pc)) $display("FAIL stream_instr c=%0d got=%h want=%h", c, instr_out, mem_word(exp_pc)); else pass_cnt++;
      end
      tick();
    end
  endtask

  // Starts at cycle 10: head pc 18, read of 18 returning, pointer 20.
  task automatic test_backpressure();
    logic [15:0] exp_ptr, exp_pc;
    instr_ready = 1'b0;
    for (int c = 10; c < 13; c++) begin
      exp_ptr = (c == 10) ? 16'd20 : 16'd22;
      total_cnt++; if (pointer !== exp_ptr) $display("FAIL bp_pointer c=%0d got=%h want=%h", c, pointer, exp_ptr); else pass_cnt++;
      total_cnt++; if (instr_valid !== 1'b1) $display("FAIL bp_valid c=%0d got=%b want=1", c, instr_valid); else pass_cnt++;
      total_cnt++; if (pc_out !== 16'd18) $display("FAIL bp_head_pc c=%0d got=%h want=%h", c, pc_out, 16'd18); else pass_cnt++;
      total_cnt++; if (instr_out !== mem_word(16'd18)) $display("FAIL bp_head_instr c=%0d got=%h want=%h", c, instr_out, mem_word(16'd18)); else pass_cnt++;
      tick();
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_pc  = 16'(18 + 2 * k);
      exp_ptr = 16'(22 + 2 * k);
      total_cnt++; if (instr_valid !== 1'b1) $display("FAIL resume_valid k=%0d got=%b want=1", k, instr_valid); else pass_cnt++;
      total_cnt++; if (pc_out !== exp_pc) $display("FAIL resume_pc k=%0d got=%h want=%h", k, pc_out, exp_pc); else pass_cnt++;
      total_cnt++; if (instr_out !== mem_word(exp_pc)) $display("FAIL resume_instr k=%0d got=%h want=%h", k, instr_out, mem_word(exp_pc)); else pass_cnt++;
      total_cnt++; if (pointer !== exp_ptr) $display("FAIL resume_pointer k=%0d got=%h want=%h", k, pointer, exp_ptr); else pass_cnt++;
      tick();
    end
  endtask

  // Starts at cycle 19: head pc 30, read of 32 returning, pointer 34.
  task automatic test_redirect_full();
    instr_ready = 1'b0;
    tick();
    total_cnt++; if (pointer !== 16'd34) $display("FAIL full_pointer got=%h want=%h", pointer, 16'd34); else pass_cnt++;
    total_cnt++; if (pc_out !== 16'd30) $display("FAIL full_head_pc got=%h want=%h", pc_out, 16'd30); else pass_cnt++;
    redirect_valid = 1'b1; redirect_target = 16'd62;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    total_cnt++; if (pointer !== 16'd62) $display("FAIL redir_pointer got=%h want=%h", pointer, 16'd62); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL redir_flushed got=%b want=0", instr_valid); else pass_cnt++;
    total_cnt++; if (misalign_err !== 1'b0) $display("FAIL redir_misalign got=%b want=0", misalign_err); else pass_cnt++;
    tick();
    total_cnt++; if (instr_valid !== 1'b1) $display("FAIL redir_valid got=%b want=1", instr_valid); else pass_cnt++;
    total_cnt++; if (pc_out !== 16'd62) $display("FAIL redir_pc got=%h want=%h", pc_out, 16'd62); else pass_cnt++;
    total_cnt++; if (instr_out !== mem_word(16'd62)) $display("FAIL redir_instr got=%h want=%h", instr_out, mem_word(16'd62)); else pass_cnt++;
    tick();
    total_cnt++; if (pc_out !== 16'd64) $display("FAIL redir_next_pc got=%h want=%h", pc_out, 16'd64); else pass_cnt++;
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_target = 16'h0005;
    tick();
    redirect_valid = 1'b0;
    total_cnt++; if (misalign_err !== 1'b1) $display("FAIL misalign_pulse got=%b want=1", misalign_err); else pass_cnt++;
    total_cnt++; if (pointer !== 16'h0004) $display("FAIL misalign_pointer got=%h want=0004", pointer); else pass_cnt++;
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL misalign_flush got=%b want=0", instr_valid); else pass_cnt++;
    tick();
    total_cnt++; if (misalign_err !== 1'b0) $display("FAIL misalign_clear got=%b want=0", misalign_err); else pass_cnt++;
    total_cnt++; if (pc_out !== 16'h0004) $display("FAIL misalign_pc got=%h want=0004", pc_out); else pass_cnt++;
    total_cnt++; if (instr_out !== mem_word(16'h0004)) $display("FAIL misalign_instr got=%h want=%h", instr_out, mem_word(16'h0004)); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc;
    redirect_valid = 1'b1; redirect_target = 16'hFFFC;
    tick();
    redirect_valid = 1'b0;
    total_cnt++; if (pointer !== 16'hFFFC) $display("FAIL wrap_pointer got=%h want=FFFC", pointer); else pass_cnt++;
    total_cnt++; if (misalign_err !== 1'b0) $display("FAIL wrap_misalign got=%b want=0", misalign_err); else pass_cnt++;
    tick();
    exp_pc = 16'hFFFC;
    for (int k = 0; k < 3; k++) begin
      total_cnt++; if (instr_valid !== 1'b1) $display("FAIL wrap_valid k=%0d got=%b want=1", k, instr_valid); else pass_cnt++;
      total_cnt++; if (pc_out !== exp_pc) $display("FAIL wrap_pc k=%0d got=%h want=%h", k, pc_out, exp_pc); else pass_cnt++;
      total_cnt++; if (instr_out !== mem_word(exp_pc)) $display("FAIL wrap_instr k=%0d got=%h want=%h", k, instr_out, mem_word(exp_pc)); else pass_cnt++;
      exp_pc = exp_pc + 16'd2;
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] exp_ptr, exp_pc;
    instr_ready = 1'b0;
    tick();
    total_cnt++; if (instr_valid !== 1'b1) $display("FAIL pre_reset_valid got=%b want=1", instr_valid); else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++; if (instr_valid !== 1'b0) $display("FAIL mid_reset_valid got=%b want=0", instr_valid); else pass_cnt++;
    total_cnt++; if (pointer !== 16'h0000) $display("FAIL mid_reset_pointer got=%h want=0000", pointer); else pass_cnt++;
    total_cnt++; if (pc_out !== 16'h0000) $display("FAIL mid_reset_pc got=%h want=0000", pc_out); else pass_cnt++;
    total_cnt++; if (instr_out !== 16'h0000) $display("FAIL mid_reset_instr got=%h want=0000", instr_out); else pass_cnt++;
    rst = 1'b0; instr_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      exp_ptr = 16'(2 * c);
      exp_pc  = 16'(2 * (c - 1));
      total_cnt++; if (pointer !== exp_ptr) $display("FAIL restart_pointer c=%0d got=%h want=%h", c, pointer, exp_ptr); else pass_cnt++;
      total_cnt++; if (instr_valid !== (c >= 1)) $display("FAIL restart_valid c=%0d got=%b want=%b", c, instr_valid, (c >= 1)); else pass_cnt++;
      if (c >= 1) begin
        total_cnt++; if (pc_out !== exp_pc) $display("FAIL restart_pc c=%0d got=%h want=%h", c, pc_out, exp_pc); else pass_cnt++;
        total_cnt++; if (instr_out !== mem_word(exp_pc)) $display("FAIL restart_instr c=%0d got=%h want=%h", c, instr_out, mem_word(exp_pc)); else pass_cnt++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misalign();
    test_wrap();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d checks want=run to completion", total_cnt);
    $fatal(1, "timeout");
  end

endmodule
